// File: rtl/mem_access_stage_if.sv
// Data-bus bundle between the memory stage and an SRAM-like data port.
// The master side issues requests; the slave side returns accept/response and read data.
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              dataReq;
  logic              dataWr;
  logic [1:0]        dataSize;
  logic [ADDR_W-1:0] dataAddr;
  logic [3:0]        dataBe;
  logic [DATA_W-1:0] dataWData;
  logic              dataAddrOk;
  logic              dataDataOk;
  logic [DATA_W-1:0] dataRData;

  modport master (
    output dataReq, dataWr, dataSize, dataAddr, dataBe, dataWData,
    input  dataAddrOk, dataDataOk, dataRData
  );

  modport slave (
    input  dataReq, dataWr, dataSize, dataAddr, dataBe, dataWData,
    output dataAddrOk, dataDataOk, dataRData
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory pipeline stage between EXEC and WB: holds one instruction, runs the data bus
// for loads/stores, aligns load data, flags misalignment and publishes a forwarding tuple.
module mem_access_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              inValid_i,
  input  logic [4:0]        inDestReg_i,
  input  logic [DATA_W-1:0] inResult_i,
  input  logic              inIsLoad_i,
  input  logic              inIsStore_i,
  input  logic [1:0]        inSize_i,
  input  logic              inSignExt_i,
  input  logic [DATA_W-1:0] inStoreData_i,
  output logic              stallIn_o,
  output logic              outValid_o,
  output logic [4:0]        outDestReg_o,
  output logic [DATA_W-1:0] outValue_o,
  output logic              excAdel_o,
  output logic              excAdes_o,
  output logic [31:0]       excBadVAddr_o,
  output logic              fwdValid_o,
  output logic [4:0]        fwdReg_o,
  output logic [DATA_W-1:0] fwdValue_o,
  mem_access_stage_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] result;
    logic              is_load;
    logic              is_store;
    logic [1:0]        size;
    logic              sign_ext;
    logic              misal;
    logic [DATA_W-1:0] wdata;
  } held_t;

  logic [1:0] state_q, state_d;
  held_t      held_q, held_d;

  logic              done_c;
  logic              stall_c;
  logic              in_mem_c;
  logic              in_misal_c;
  logic              start_req_c;
  logic              live_c;
  logic              alu_c;
  logic              ld_c;
  logic              st_c;
  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;
  logic [DATA_W-1:0] ld_val_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  // Bus response that ends the current transaction; a stray response in IDLE is ignored.
  always_comb begin
    done_c = 1'b0;
    unique case (state_q)
      ST_REQ:   done_c = bus.dataAddrOk & bus.dataDataOk;
      ST_WAIT:  done_c = bus.dataDataOk;
      ST_DRAIN: done_c = bus.dataDataOk;
      default:  done_c = 1'b0;
    endcase
    stall_c = (state_q != ST_IDLE) & ~done_c;
  end

  always_comb begin
    in_mem_c    = inIsLoad_i | inIsStore_i;
    in_misal_c  = ((inSize_i == 2'd1) && inResult_i[0]) ||
                  (inSize_i[1] && (inResult_i[1:0] != 2'b00));
    start_req_c = ~stall_c & inValid_i & ~flush_i & in_mem_c & ~in_misal_c;
  end

  // Held instruction register: flush wins over capture and leaves a bubble.
  always_comb begin
    held_d = held_q;
    if (flush_i) begin
      held_d = '0;
    end else if (!stall_c) begin
      held_d = '0;
      if (inValid_i) begin
        held_d.valid    = 1'b1;
        held_d.dest     = inDestReg_i;
        held_d.result   = inResult_i;
        held_d.is_load  = inIsLoad_i;
        held_d.is_store = inIsStore_i & ~inIsLoad_i;
        held_d.size     = inSize_i;
        held_d.sign_ext = inSignExt_i;
        held_d.misal    = in_mem_c & in_misal_c;
        held_d.wdata    = inStoreData_i;
      end
    end
  end

  // Bus FSM; a new aligned memory op enters REQ at its capture edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_REQ: begin
        if (bus.dataAddrOk && bus.dataDataOk) state_d = ST_IDLE;
        else if (bus.dataAddrOk)              state_d = flush_i ? ST_DRAIN : ST_WAIT;
        else if (flush_i)                     state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (bus.dataDataOk)  state_d = ST_IDLE;
        else if (flush_i)    state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.dataDataOk)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_req_c) state_d = ST_REQ;
  end

  // Lane selection and extension of returned load data.
  always_comb begin
    unique case (held_q.result[1:0])
      2'd0:    ld_byte_c = bus.dataRData[7:0];
      2'd1:    ld_byte_c = bus.dataRData[15:8];
      2'd2:    ld_byte_c = bus.dataRData[23:16];
      default: ld_byte_c = bus.dataRData[31:24];
    endcase
    ld_half_c = held_q.result[1] ? bus.dataRData[31:16] : bus.dataRData[15:0];
    unique case (held_q.size)
      2'd0:    ld_val_c = held_q.sign_ext ? {{24{ld_byte_c[7]}}, ld_byte_c}
                                          : {24'd0, ld_byte_c};
      2'd1:    ld_val_c = held_q.sign_ext ? {{16{ld_half_c[15]}}, ld_half_c}
                                          : {16'd0, ld_half_c};
      default: ld_val_c = bus.dataRData;
    endcase
  end

  always_comb begin
    live_c = held_q.valid & ~flush_i;
    alu_c  = live_c & ~held_q.is_load & ~held_q.is_store;
    ld_c   = live_c & held_q.is_load & ~held_q.misal;
    st_c   = live_c & held_q.is_store & ~held_q.misal;
  end

  // Request side of the data bus, quiet outside REQ.
  always_comb begin
    bus.dataReq   = 1'b0;
    bus.dataWr    = 1'b0;
    bus.dataSize  = 2'd0;
    bus.dataAddr  = '0;
    bus.dataBe    = 4'b0000;
    bus.dataWData = '0;
    if (state_q == ST_REQ) begin
      bus.dataReq  = 1'b1;
      bus.dataWr   = held_q.is_store;
      bus.dataSize = held_q.size;
      bus.dataAddr = held_q.size[1] ? ADDR_W'(held_q.result)
                                    : ADDR_W'({held_q.result[DATA_W-1:2], 2'b00});
      unique case (held_q.size)
        2'd0: begin
          bus.dataBe    = 4'b0001 << held_q.result[1:0];
          bus.dataWData = {4{held_q.wdata[7:0]}};
        end
        2'd1: begin
          bus.dataBe    = held_q.result[1] ? 4'b1100 : 4'b0011;
          bus.dataWData = {2{held_q.wdata[15:0]}};
        end
        default: begin
          bus.dataBe    = 4'b1111;
          bus.dataWData = held_q.wdata;
        end
      endcase
    end
  end

  // WB, exception and forwarding outputs for the held instruction.
  always_comb begin
    stallIn_o     = stall_c;
    outValid_o    = 1'b0;
    outDestReg_o  = '0;
    outValue_o    = '0;
    excAdel_o     = 1'b0;
    excAdes_o     = 1'b0;
    excBadVAddr_o = '0;
    fwdValid_o    = 1'b0;
    fwdReg_o      = '0;
    fwdValue_o    = '0;

    if (alu_c) begin
      outValid_o   = 1'b1;
      outDestReg_o = held_q.dest;
      outValue_o   = held_q.result;
      fwdValid_o   = 1'b1;
      fwdReg_o     = held_q.dest;
      fwdValue_o   = held_q.result;
    end

    if (ld_c) begin
      fwdReg_o = held_q.dest;
      if (done_c) begin
        outValid_o   = 1'b1;
        outDestReg_o = held_q.dest;
        outValue_o   = ld_val_c;
        fwdValid_o   = 1'b1;
        fwdValue_o   = ld_val_c;
      end
    end

    if (st_c && done_c) begin
      outValid_o = 1'b1;
    end

    if (live_c && held_q.misal) begin
      excAdel_o     = held_q.is_load;
      excAdes_o     = held_q.is_store;
      excBadVAddr_o = 32'(held_q.result);
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: the bench plays EXEC and the data memory cycle by cycle.
module tb_mem_access_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [4:0]  in_dest;
  logic [31:0] in_result;
  logic        in_ld;
  logic        in_st;
  logic [1:0]  in_size;
  logic        in_sx;
  logic [31:0] in_sdata;

  logic        stall_in;
  logic        out_valid;
  logic [4:0]  out_dest;
  logic [31:0] out_value;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] exc_badv;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_value;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush),
    .inValid_i     (in_valid),
    .inDestReg_i   (in_dest),
    .inResult_i    (in_result),
    .inIsLoad_i    (in_ld),
    .inIsStore_i   (in_st),
    .inSize_i      (in_size),
    .inSignExt_i   (in_sx),
    .inStoreData_i (in_sdata),
    .stallIn_o     (stall_in),
    .outValid_o    (out_valid),
    .outDestReg_o  (out_dest),
    .outValue_o    (out_value),
    .excAdel_o     (exc_adel),
    .excAdes_o     (exc_ades),
    .excBadVAddr_o (exc_badv),
    .fwdValid_o    (fwd_valid),
    .fwdReg_o      (fwd_reg),
    .fwdValue_o    (fwd_value),
    .bus           (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] dest, input logic [31:0] res, input logic ld,
                       input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] sd);
    in_valid  = 1'b1;
    in_dest   = dest;
    in_result = res;
    in_ld     = ld;
    in_st     = st;
    in_size   = sz;
    in_sx     = sx;
    in_sdata  = sd;
  endtask

  task automatic clr_in();
    in_valid  = 1'b0;
    in_dest   = '0;
    in_result = '0;
    in_ld     = 1'b0;
    in_st     = 1'b0;
    in_size   = 2'd0;
    in_sx     = 1'b0;
    in_sdata  = '0;
  endtask

  task automatic bus_idle();
    bus.dataAddrOk = 1'b0;
    bus.dataDataOk = 1'b0;
    bus.dataRData  = '0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clr_in();
    bus_idle();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall",   32'(stall_in),    32'd0);
    check("rst_outv",    32'(out_valid),   32'd0);
    check("rst_fwdv",    32'(fwd_valid),   32'd0);
    check("rst_fwdreg",  32'(fwd_reg),     32'd0);
    check("rst_req",     32'(bus.dataReq), 32'd0);
    check("rst_adel",    32'(exc_adel),    32'd0);
    check("rst_badv",    exc_badv,         32'd0);
    reset = 1'b0;

    // ALU op forwards the cycle after capture
    @(negedge clk); issue(5'd5, 32'h1234, 0, 0, 2'd0, 0, 0);
    @(negedge clk); clr_in(); #1;
    check("alu_fwdv",    32'(fwd_valid), 32'd1);
    check("alu_fwdreg",  32'(fwd_reg),   32'd5);
    check("alu_fwdval",  fwd_value,      32'h1234);
    check("alu_outv",    32'(out_valid), 32'd1);
    check("alu_outdst",  32'(out_dest),  32'd5);
    check("alu_stall",   32'(stall_in),  32'd0);
    @(negedge clk); #1;
    check("alu_pulse",   32'(out_valid), 32'd0);

    // signed byte load 0x1003, slow accept and slow response
    @(negedge clk); issue(5'd7, 32'h1003, 1, 0, 2'd0, 1, 0);
    @(negedge clk); clr_in(); #1;
    check("lb_req",      32'(bus.dataReq),  32'd1);
    check("lb_wr",       32'(bus.dataWr),   32'd0);
    check("lb_addr",     bus.dataAddr,      32'h1000);
    check("lb_be",       32'(bus.dataBe),   32'h8);
    check("lb_stall1",   32'(stall_in),     32'd1);
    check("lb_fwdv1",    32'(fwd_valid),    32'd0);
    check("lb_fwdreg",   32'(fwd_reg),      32'd7);
    @(negedge clk); #1;
    check("lb_req2",     32'(bus.dataReq),  32'd1);
    check("lb_fwdv2",    32'(fwd_valid),    32'd0);
    @(negedge clk); bus.dataAddrOk = 1'b1; #1;
    check("lb_stall3",   32'(stall_in),     32'd1);
    @(negedge clk); bus.dataAddrOk = 1'b0; #1;
    check("lb_wait_req", 32'(bus.dataReq),  32'd0);
    check("lb_stall4",   32'(stall_in),     32'd1);
    check("lb_fwdv4",    32'(fwd_valid),    32'd0);
    @(negedge clk); #1;
    check("lb_stall5",   32'(stall_in),     32'd1);
    @(negedge clk);
    bus.dataDataOk = 1'b1;
    bus.dataRData  = 32'h80FF0011;
    issue(5'd9, 32'h55, 0, 0, 2'd2, 0, 0);
    #1;
    check("lb_fwdv",     32'(fwd_valid),    32'd1);
    check("lb_fwdval",   fwd_value,         32'hFFFFFF80);
    check("lb_outv",     32'(out_valid),    32'd1);
    check("lb_outval",   out_value,         32'hFFFFFF80);
    check("lb_outdst",   32'(out_dest),     32'd7);
    check("lb_stall_dn", 32'(stall_in),     32'd0);
    @(negedge clk); bus_idle(); clr_in(); #1;
    check("lb_next_reg", 32'(fwd_reg),      32'd9);
    check("lb_next_val", fwd_value,         32'h55);
    check("lb_next_outv",32'(out_valid),    32'd1);

    // store half 0x2002
    @(negedge clk); issue(5'd8, 32'h2002, 0, 1, 2'd1, 0, 32'h0000ABCD);
    @(negedge clk); clr_in(); bus.dataAddrOk = 1'b1; #1;
    check("sh_req",      32'(bus.dataReq),  32'd1);
    check("sh_wr",       32'(bus.dataWr),   32'd1);
    check("sh_size",     32'(bus.dataSize), 32'd1);
    check("sh_addr",     bus.dataAddr,      32'h2000);
    check("sh_be",       32'(bus.dataBe),   32'hC);
    check("sh_wdata",    bus.dataWData,     32'hABCDABCD);
    check("sh_fwdreg",   32'(fwd_reg),      32'd0);
    @(negedge clk); bus.dataAddrOk = 1'b0; bus.dataDataOk = 1'b1; #1;
    check("sh_outv",     32'(out_valid),    32'd1);
    check("sh_outdst",   32'(out_dest),     32'd0);
    check("sh_stall",    32'(stall_in),     32'd0);
    @(negedge clk); bus_idle();

    // store byte 0x2001, accept and complete together
    issue(5'd0, 32'h2001, 0, 1, 2'd0, 0, 32'h12345678);
    @(negedge clk); clr_in(); bus.dataAddrOk = 1'b1; bus.dataDataOk = 1'b1; #1;
    check("sb_be",       32'(bus.dataBe),   32'h2);
    check("sb_wdata",    bus.dataWData,     32'h78787878);
    check("sb_outv",     32'(out_valid),    32'd1);
    check("sb_stall",    32'(stall_in),     32'd0);
    @(negedge clk); bus_idle();

    // misaligned word load 0x3001
    issue(5'd4, 32'h3001, 1, 0, 2'd2, 0, 0);
    @(negedge clk); clr_in(); #1;
    check("adel",        32'(exc_adel),     32'd1);
    check("adel_ades",   32'(exc_ades),     32'd0);
    check("adel_badv",   exc_badv,          32'h3001);
    check("adel_req",    32'(bus.dataReq),  32'd0);
    check("adel_fwdreg", 32'(fwd_reg),      32'd0);
    check("adel_outv",   32'(out_valid),    32'd0);
    @(negedge clk); #1;
    check("adel_pulse",  32'(exc_adel),     32'd0);
    check("adel_req2",   32'(bus.dataReq),  32'd0);

    // misaligned half store 0x3003
    issue(5'd0, 32'h3003, 0, 1, 2'd1, 0, 0);
    @(negedge clk); clr_in(); #1;
    check("ades",        32'(exc_ades),     32'd1);
    check("ades_adel",   32'(exc_adel),     32'd0);
    check("ades_badv",   exc_badv,          32'h3003);
    check("ades_req",    32'(bus.dataReq),  32'd0);

    // flush while waiting for load data -> drain
    @(negedge clk); issue(5'd3, 32'h5000, 1, 0, 2'd2, 0, 0);
    @(negedge clk); clr_in(); bus.dataAddrOk = 1'b1; #1;
    check("fl_req",      32'(bus.dataReq),  32'd1);
    @(negedge clk); bus.dataAddrOk = 1'b0; flush = 1'b1; #1;
    check("fl_fwdreg",   32'(fwd_reg),      32'd0);
    check("fl_stall",    32'(stall_in),     32'd1);
    @(negedge clk); flush = 1'b0; #1;
    check("dr_stall",    32'(stall_in),     32'd1);
    check("dr_req",      32'(bus.dataReq),  32'd0);
    check("dr_outv",     32'(out_valid),    32'd0);
    @(negedge clk);
    bus.dataDataOk = 1'b1;
    bus.dataRData  = 32'hDEADBEEF;
    issue(5'd10, 32'h77, 0, 0, 2'd2, 0, 0);
    #1;
    check("dr_done_outv",32'(out_valid),    32'd0);
    check("dr_done_fwdv",32'(fwd_valid),    32'd0);
    check("dr_done_stl", 32'(stall_in),     32'd0);
    @(negedge clk); bus_idle(); clr_in(); #1;
    check("dr_next_reg", 32'(fwd_reg),      32'd10);
    check("dr_next_val", fwd_value,         32'h77);
    check("dr_next_outv",32'(out_valid),    32'd1);

    // lhu 0x4002 with accept and data in the same cycle
    @(negedge clk); issue(5'd6, 32'h4002, 1, 0, 2'd1, 0, 0);
    @(negedge clk); clr_in();
    bus.dataAddrOk = 1'b1; bus.dataDataOk = 1'b1; bus.dataRData = 32'h80010000;
    #1;
    check("lhu_addr",    bus.dataAddr,      32'h4000);
    check("lhu_fwdv",    32'(fwd_valid),    32'd1);
    check("lhu_fwdval",  fwd_value,         32'h00008001);
    check("lhu_fwdreg",  32'(fwd_reg),      32'd6);
    check("lhu_outv",    32'(out_valid),    32'd1);
    check("lhu_stall",   32'(stall_in),     32'd0);
    @(negedge clk); bus_idle(); #1;
    check("lhu_idle",    32'(bus.dataReq),  32'd0);

    // lh 0x4002 sign-extends
    issue(5'd6, 32'h4002, 1, 0, 2'd1, 1, 0);
    @(negedge clk); clr_in();
    bus.dataAddrOk = 1'b1; bus.dataDataOk = 1'b1; bus.dataRData = 32'h80010000;
    #1;
    check("lh_fwdval",   fwd_value,         32'hFFFF8001);
    @(negedge clk); bus_idle();

    // lbu 0x1001 zero-extends lane 1
    issue(5'd13, 32'h1001, 1, 0, 2'd0, 0, 0);
    @(negedge clk); clr_in();
    bus.dataAddrOk = 1'b1; bus.dataDataOk = 1'b1; bus.dataRData = 32'h0000A500;
    #1;
    check("lbu_fwdval",  fwd_value,         32'h000000A5);
    check("lbu_be",      32'(bus.dataBe),   32'h2);
    @(negedge clk); bus_idle();

    // flush in REQ before accept drops the request
    issue(5'd11, 32'h6000, 1, 0, 2'd2, 0, 0);
    @(negedge clk); clr_in(); flush = 1'b1; #1;
    check("flr_outv",    32'(out_valid),    32'd0);
    check("flr_fwdreg",  32'(fwd_reg),      32'd0);
    @(negedge clk); flush = 1'b0; #1;
    check("flr_req",     32'(bus.dataReq),  32'd0);
    check("flr_stall",   32'(stall_in),     32'd0);

    // reset mid-transaction; later stray response ignored
    @(negedge clk); issue(5'd2, 32'h7000, 1, 0, 2'd2, 0, 0);
    @(negedge clk); clr_in(); bus.dataAddrOk = 1'b1;
    @(negedge clk); bus.dataAddrOk = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0; bus.dataDataOk = 1'b1; bus.dataRData = 32'h12345678; #1;
    check("rm_outv",     32'(out_valid),    32'd0);
    check("rm_fwdv",     32'(fwd_valid),    32'd0);
    check("rm_stall",    32'(stall_in),     32'd0);
    check("rm_req",      32'(bus.dataReq),  32'd0);
    @(negedge clk); bus_idle(); #1;
    check("rm_req2",     32'(bus.dataReq),  32'd0);

    // flush and capture together load a bubble
    issue(5'd12, 32'h99, 0, 0, 2'd2, 0, 0);
    flush = 1'b1;
    @(negedge clk); clr_in(); flush = 1'b0; #1;
    check("fc_outv",     32'(out_valid),    32'd0);
    check("fc_fwdreg",   32'(fwd_reg),      32'd0);
    check("fc_fwdv",     32'(fwd_valid),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory pipeline stage between EXEC and WB.
- Holds the in-flight instruction and drives the SRAM-like data bus for loads and stores.
- Aligns and extends load data, and flags address-misalignment exceptions.
- Publishes a (valid, reg, value) forwarding tuple that the operand forward controller consumes as a forwarding source.
- A load's tuple stays not-valid until the data returns, so consumers stall instead of reading stale values.

Parameters:
- ADDR_W, 32, data bus address width
- DATA_W, 32, data word width (fixed at 32; other values unsupported)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  kill the held instruction (exception/eret from WB)
- inValid  in  1  EXEC presents an instruction
- inDestReg  in  5  GPR written by instruction, 0 = none
- inResult  in  32  ALU result, or effective address for load/store
- inIsLoad  in  1  instruction is a load
- inIsStore  in  1  instruction is a store
- inSize  in  2  0=byte, 1=half, 2=word
- inSignExt  in  1  sign-extend byte/half load
- inStoreData  in  32  store source register value
- stallIn  out  1  stage busy; EXEC must hold its outputs
- outValid  out  1  instruction complete, passed to WB this cycle
- outDestReg  out  5  GPR to write at WB
- outValue  out  32  result to WB
- excAdel  out  1  misaligned load
- excAdes  out  1  misaligned store
- excBadVAddr  out  32  faulting address
- fwdValid  out  1  fwdValue is final
- fwdReg  out  5  forwarding destination, 0 = none
- fwdValue  out  32  forwarding value
- dataReq  out  1  bus request
- dataWr  out  1  1=store
- dataSize  out  2  mirrors inSize
- dataAddr  out  32  word-aligned address for byte/half, exact address for word
- dataBe  out  4  byte enables
- dataWData  out  32  lane-replicated store data
- dataAddrOk  in  1  request accepted
- dataDataOk  in  1  response / write-complete
- dataRData  in  32  read data

Behaviour:
- Reset: state IDLE; all outputs 0; held register cleared (dest 0, valid 0).
- Capture: held register loads EXEC inputs at a clock edge when stallIn=0. An edge with stallIn=0 and inValid=0 loads a bubble.
- Misalignment check at capture: half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned load sets excAdel for 1 cycle; misaligned store sets excAdes for 1 cycle.
  - excBadVAddr = address.
  - No bus request is issued; fwdReg=0, outDestReg=0.
- Non-memory instruction:
  - fwdValid=1, fwdReg=inDestReg, fwdValue=inResult in the cycle after capture.
  - outValid=1 in that cycle; zero added latency.
- FSM states:
  - IDLE: memory op held and aligned → REQ.
  - REQ: dataReq=1. dataAddrOk=1 → WAIT. If dataAddrOk and dataDataOk arrive together, go straight to IDLE (complete).
  - WAIT: dataReq=0. dataDataOk=1 → IDLE, complete.
  - DRAIN: entered from WAIT on flush; discards response; dataDataOk → IDLE.
- stallIn=1 whenever state is REQ, WAIT or DRAIN. It falls in the completion cycle, so the next instruction is captured at that edge.
- Load tuple:
  - fwdReg=dest throughout; fwdValid=0 until dataDataOk.
  - In the completion cycle, fwdValid=1 and fwdValue=extracted data, combinationally from dataRData.
  - Registered result is kept afterwards until the next capture.
- Load extraction:
  - byte = rdata[8*a+7:8*a], where a=addr[1:0];
  - half = rdata[16*a1+15:16*a1], where a1=addr[1];
  - zero- or sign-extended per inSignExt.
- Store: fwdReg=0, outDestReg=0. Byte enables are byte 0001<<a, half 0011<<(2*a1), word 1111. dataWData replicates the byte/half into all lanes.
- outValid pulses 1 cycle at completion; a flushed instruction never asserts outValid.
- Flush:
  - In IDLE or REQ before dataAddrOk: drop immediately, no request issued afterwards, state IDLE.
  - Flush in the same cycle as dataAddrOk in REQ: go to DRAIN.
  - In WAIT: go to DRAIN.
  - Flushed instruction: fwdReg=0, outValid=0, exc outputs=0.
- Simultaneous flush and capture: flush wins; a bubble is loaded.
- reset mid-transaction: return to IDLE; any later stray dataDataOk in IDLE is ignored.

Test Plan:
- ALU op inDestReg=5, inResult=0x1234 → next cycle fwdValid=1, fwdReg=5, fwdValue=0x1234, outValid=1, stallIn=0.
- Load byte signed addr=0x1003, memory word 0x80FF0011, addrOk after 2 cycles, dataOk after 3 more:
  - while pending: fwdValid=0 and stallIn=1;
  - at completion: fwdValue=0xFFFFFF80, outValid=1.
- Store half addr=0x2002, data=0x0000ABCD → dataBe=1100, dataWData=0xABCDABCD, dataWr=1; fwdReg=0.
- Load word addr=0x3001 → excAdel=1, excBadVAddr=0x3001, dataReq never asserted, fwdReg=0.
- Load accepted (WAIT) then flush → DRAIN, stallIn=1 until dataOk; then outValid stays 0 and the next instruction is captured.
- addrOk and dataOk asserted together in REQ, lhu addr=0x4002, rdata 0x8001_0000 → completes the same cycle, fwdValue=0x00008001.
